// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT commutator datapath.
//   DATA_W_DEF : default width of one real/imag component
//   cplx_t     : complex sample (re, im) at the default width
//   cm_state_t : commutator FSM states
package fft_pkg;

    localparam int DATA_W_DEF = 16;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] re;
        logic [DATA_W_DEF-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN
    } cm_state_t;

endpackage

// File: rtl/cm_delay_line.sv
// cm_delay_line: DEPTH-deep shift register of W-bit words (a packed complex
// sample) that advances only while en is high.
//   CLK  : clock, rising edge
//   RSTn : asynchronous active-low clear of every stage
//   en   : shift one position
//   din  : word entering stage 0
//   dout : oldest word (stage DEPTH-1), i.e. din delayed by DEPTH shifts
module cm_delay_line #(
    parameter int DEPTH = 16,
    parameter int W     = 32
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [DEPTH-1:0][W-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = en ? {sr_q[DEPTH-2:0], din} : sr_q;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/commutator_postdelay.sv
// commutator_postdelay: radix-2 SDF commutator with post-delay. Swaps the
// two butterfly paths every D accepted pairs, delays the selected path by D
// pairs and emits the re-aligned pair to the next stage; a frame ends with a
// D-cycle drain that flushes the delay line.
//   CLK, RSTn                     : clock, asynchronous active-low reset
//   in_valid, in_last             : input pair strobe / final pair of frame
//   in0_re/im                     : undelayed upper path
//   in1_re/im                     : lower path, pre-delayed upstream
//   out_valid, out_last           : output pair strobe / final pair of frame
//   out0_re/im, out1_re/im        : aligned output pair
//   err                           : sticky protocol error
// Build option: define CM_OUT_REG_EN to add one more register stage on all
// outputs (latency 2 instead of 1).
module commutator_postdelay
    import fft_pkg::*;
#(
    parameter int DELAY_CYCLES = 16,
    parameter int DATA_W       = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in0_re,
    input  logic [DATA_W-1:0] in0_im,
    input  logic [DATA_W-1:0] in1_re,
    input  logic [DATA_W-1:0] in1_im,
    output logic              out_valid,
    output logic              out_last,
    output logic [DATA_W-1:0] out0_re,
    output logic [DATA_W-1:0] out0_im,
    output logic [DATA_W-1:0] out1_re,
    output logic [DATA_W-1:0] out1_im,
    output logic              err
);

    localparam int LD = $clog2(DELAY_CYCLES);
    // k spans one 2D period, so wrap-around gives k mod 2D for free
    localparam int KW = LD + 1;
    localparam int PW = 2 * DATA_W;
    localparam logic [KW-1:0] K_LAST = KW'(DELAY_CYCLES - 1);

    cm_state_t       state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic            err_q, err_d;
    logic            vld_q, vld_d;
    logic            last_q, last_d;
    logic [2*PW-1:0] dat_q, dat_d;
    logic            acc, sel, dl_en;
    logic [PW-1:0]   a, b, dl_in, dl_out;

    always_comb begin
        acc     = in_valid && (state_q != DRAIN);
        sel     = k_q[LD];
        a       = sel ? {in1_re, in1_im} : {in0_re, in0_im};
        b       = sel ? {in0_re, in0_im} : {in1_re, in1_im};
        dl_en   = acc || (state_q == DRAIN);
        dl_in   = (state_q == DRAIN) ? '0 : a;
        state_d = state_q;
        k_d     = k_q;
        err_d   = err_q;
        vld_d   = 1'b0;
        last_d  = 1'b0;
        dat_d   = dat_q;
        if (state_q == DRAIN) begin
            // k is reused as the drain cycle counter; zeros are shifted in,
            // so the line is empty again when the frame ends
            vld_d   = 1'b1;
            last_d  = (k_q == K_LAST);
            dat_d   = {dl_out, {PW{1'b0}}};
            k_d     = last_d ? '0 : k_q + 1'b1;
            state_d = last_d ? IDLE : DRAIN;
            err_d   = err_q | in_valid;
        end else if (acc) begin
            k_d     = k_q + 1'b1;
            vld_d   = (state_q == RUN);
            dat_d   = vld_d ? {dl_out, b} : dat_q;
            state_d = (state_q == RUN || k_q == K_LAST) ? RUN : FILL;
            if (in_last) begin
                state_d = DRAIN;
                k_d     = '0;
                err_d   = err_q | (k_q != {KW{1'b1}});
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            k_q     <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            dat_q   <= dat_d;
        end
    end

    cm_delay_line #(
        .DEPTH (DELAY_CYCLES),
        .W     (PW)
    ) u_dl (
        .CLK  (CLK),
        .RSTn (RSTn),
        .en   (dl_en),
        .din  (dl_in),
        .dout (dl_out)
    );

    logic            vld_o, last_o, err_o;
    logic [2*PW-1:0] dat_o;

`ifdef CM_OUT_REG_EN
    logic            vld2_q, last2_q, err2_q;
    logic [2*PW-1:0] dat2_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            vld2_q  <= 1'b0;
            last2_q <= 1'b0;
            err2_q  <= 1'b0;
            dat2_q  <= '0;
        end else begin
            vld2_q  <= vld_q;
            last2_q <= last_q;
            err2_q  <= err_q;
            dat2_q  <= dat_q;
        end
    end

    assign vld_o  = vld2_q;
    assign last_o = last2_q;
    assign err_o  = err2_q;
    assign dat_o  = dat2_q;
`else
    assign vld_o  = vld_q;
    assign last_o = last_q;
    assign err_o  = err_q;
    assign dat_o  = dat_q;
`endif

    assign out_valid = vld_o;
    assign out_last  = last_o;
    assign err       = err_o;
    assign {out0_re, out0_im, out1_re, out1_im} = dat_o;

endmodule

// File: tb/tb_commutator_postdelay.sv
// tb_commutator_postdelay: scoreboard bench for commutator_postdelay (D=4).
module tb_commutator_postdelay;

    localparam int D = 4;
    localparam int W = 16;
`ifdef CM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         CLK = 1'b0;
    logic         RSTn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [W-1:0] in0_re = '0;
    logic [W-1:0] in0_im = '0;
    logic [W-1:0] in1_re = '0;
    logic [W-1:0] in1_im = '0;
    logic         out_valid, out_last, err;
    logic [W-1:0] out0_re, out0_im, out1_re, out1_im;

    typedef struct {
        int r0;
        int r1;
        bit last;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int first_cyc = -1;
    int acc_cyc = 0;

    // hand-computed (out0_re, out1_re) for the 16-pair frame in0_re=k, in1_re=100+k
    int e0[16] = '{0, 1, 2, 3, 104, 105, 106, 107, 8, 9, 10, 11, 112, 113, 114, 115};
    int e1[16] = '{4, 5, 6, 7, 108, 109, 110, 111, 12, 13, 14, 15, 0, 0, 0, 0};

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    commutator_postdelay #(
        .DELAY_CYCLES (D),
        .DATA_W       (W)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in0_re    (in0_re),
        .in0_im    (in0_im),
        .in1_re    (in1_re),
        .in1_im    (in1_im),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out0_re   (out0_re),
        .out0_im   (out0_im),
        .out1_re   (out1_re),
        .out1_im   (out1_im),
        .err       (err)
    );

    function automatic void check(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // monitor: pops one expectation per presented output pair
    always @(negedge CLK) begin
        if (RSTn && out_valid) begin
            exp_t e;
            if (first_cyc < 0) first_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out0_re", longint'(out0_re), e.r0);
                check("out1_re", longint'(out1_re), e.r1);
                check("out_last", longint'(out_last), longint'(e.last));
                check("out_im", longint'({out0_im, out1_im}), 0);
            end
        end
    end

    task automatic push(int r0, int r1, bit last);
        exp_t e;
        e.r0 = r0;
        e.r1 = r1;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic push_frame();
        for (int i = 0; i < 16; i++) push(e0[i], e1[i], i == 15);
    endtask

    // n pairs, optional 1-cycle bubble after each, in_last on pair last_at,
    // then junk cycles of in_valid (land in DRAIN when no gap)
    task automatic send(int n, bit gap, int last_at, int junk);
        first_cyc = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            in_valid = 1'b1;
            in_last = (k == last_at);
            in0_re = W'(k);
            in1_re = W'(100 + k);
            if (k == D) acc_cyc = cyc + 1;
            if (gap) begin
                @(negedge CLK);
                in_valid = 1'b0;
                in_last = 1'b0;
            end
        end
        for (int j = 0; j < junk; j++) begin
            @(negedge CLK);
            in_valid = 1'b1;
            in_last = 1'b0;
            in0_re = W'(999);
            in1_re = W'(777);
        end
        @(negedge CLK);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_empty(string name);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge CLK);
        repeat (4) @(negedge CLK);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_err", err, 0);
        check("rst_data", longint'({out0_re, out0_im, out1_re, out1_im}), 0);
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;

        // back-to-back frame
        push_frame();
        send(16, 1'b0, 15, 0);
        wait_empty("t1_sb_empty");
        check("t1_latency", first_cyc, acc_cyc + LAT - 1);
        check("t1_err", err, 0);

        // bubble after every pair
        push_frame();
        send(16, 1'b1, 15, 0);
        wait_empty("t2_sb_empty");
        check("t2_latency", first_cyc, acc_cyc + LAT - 1);
        check("t2_err", err, 0);

        // in_last on k=5: error, still drains 4 pairs
        push(0, 4, 0);
        push(1, 5, 0);
        push(2, 0, 0);
        push(3, 0, 0);
        push(104, 0, 0);
        push(105, 0, 1);
        send(6, 1'b0, 5, 0);
        wait_empty("t3_sb_empty");
        check("t3_err", err, 1);
        push_frame();
        send(16, 1'b0, 15, 0);
        wait_empty("t3_next_sb_empty");
        check("t3_err_sticky", err, 1);

        // asynchronous reset mid-frame at k=6
        if (LAT == 1) push(0, 4, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            in_valid = 1'b1;
            in_last = 1'b0;
            in0_re = W'(k);
            in1_re = W'(100 + k);
        end
        @(posedge CLK);
        #2;
        check("t4_pre_valid", out_valid, 1);
        RSTn = 1'b0;
        in_valid = 1'b0;
        #1;
        check("t4_rst_valid", out_valid, 0);
        check("t4_rst_last", out_last, 0);
        check("t4_rst_err", err, 0);
        check("t4_rst_data", longint'({out0_re, out0_im, out1_re, out1_im}), 0);
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        check("t4_sb_empty", sb.size(), 0);
        sb.delete();
        push_frame();
        send(16, 1'b0, 15, 0);
        wait_empty("t4_next_sb_empty");
        check("t4_err", err, 0);

        // in_valid during DRAIN: ignored, flags err
        push_frame();
        send(16, 1'b0, 15, 2);
        wait_empty("t5_sb_empty");
        check("t5_err", err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
